pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with a valid/ready handshake. It is the successor
//  to the fixed-field IF/ID..MEM/WB registers.
//  Adds per-stage valid, back-pressure (stall), synchronous flush (bubble insert) and an
//  optional 2-entry skid buffer. The skid buffer gives full throughput with a registered in_ready.
//  Sits between any two pipeline stages. Callers concatenate their control and data fields into in_data.
// PARAMETERS
//  DATA_W  32   width of the payload carried through the stage
//  BUBBLE  0    DATA_W-bit value driven on out_data whenever out_valid=0 (NOP encoding)
//  SKID    1    1: 2-entry skid, in_ready registered; 0: 1-entry, in_ready = !out_valid | out_ready
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous flush: empties the stage (branch/jump squash)
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept a payload this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       payload at out_data is valid
//  out_ready  in   1       downstream accepts; 0 = stall
//  out_data   out  DATA_W  payload to the next stage (BUBBLE when out_valid=0)
//  count      out  2       occupancy 0..2 (max 1 when SKID=0)
// BEHAVIOUR
//  Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  Priority: reset > flush > normal operation.
//  Reset (reset=1 at edge): count=0, out_valid=0, out_data=BUBBLE, skid reg=BUBBLE.
//   - in_ready=0 while reset is high.
//   - in_ready=1 from the first cycle after reset deasserts.
//  Flush (flush=1 at edge, reset=0):
//   - Next state is EMPTY with out_data=BUBBLE.
//   - A payload that handshakes in the flush cycle is discarded.
//   - A payload that out_fires in the flush cycle is still consumed downstream.
//  Latency: in_fire in cycle N -> out_valid=1, out_data=payload in cycle N+1. Throughput 1/cycle.
//  Ordering: strict FIFO. No payload is ever duplicated or dropped, except on flush or reset.
//  SKID=1 FSM (state = count); out_data is the main reg; in_ready = (count!=2), registered:
//   EMPTY(0): in_fire -> ONE, main<=in_data.
//   ONE(1):
//    - in_fire & !out_fire -> TWO, skid<=in_data.
//    - !in_fire & out_fire -> EMPTY, main<=BUBBLE.
//    - in_fire & out_fire  -> ONE, main<=in_data.
//   TWO(2):
//    - out_fire -> ONE, main<=skid, skid<=BUBBLE.
//    - Otherwise hold. in_valid is ignored because in_ready=0.
//  SKID=0: single main reg; count in {0,1}.
//   - in_ready = !out_valid | out_ready (combinational path from out_ready).
//   - in_fire loads main.
//   - out_fire & !in_fire empties the stage (main<=BUBBLE).
//  Stall: out_valid & !out_ready holds out_valid and out_data stable until out_fire.
//  Data regs load only on the listed transitions. No toggling when the stage is idle.
//  Held-value rule: in_data is don't-care when in_valid=0; its value never reaches out_data.
//  out_valid = (count!=0).
//  count never exceeds 2 (SKID=1) or 1 (SKID=0). Exceeding it is an assertion failure in the bench.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1, in_data=32'hDEAD0001.
//    -> out_valid=0, out_data=0, count=0, in_ready=0; in_ready=1 in the cycle after release.
//  2 Streaming, SKID=1, out_ready=1: send 1,2,3,4 on consecutive cycles.
//    -> out_data 1,2,3,4 on cycles N+1..N+4; count stays 1; in_ready stays 1.
//  3 Stall: out_ready=0 while sending A1,A2,A3.
//    -> A1 and A2 accepted, count=2, in_ready=0, A3 held upstream.
//    -> Raise out_ready: outputs A1,A2,A3 in order, no loss.
//  4 Flush with count=2 and in_valid=1 (payload 77).
//    -> Next cycle count=0, out_valid=0, out_data=BUBBLE; 77 never appears at the output.
//  5 SKID=0, count=1, out_ready=1, in_valid=1.
//    -> in_ready=1 in the same cycle; new data appears next cycle with count=1.
//  6 Reset and flush together while count=2.
//    -> Reset values apply; in_ready=0 for that cycle; random traffic is checked against a reference FIFO model.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready handshake, flush and optional 2-entry skid
// out_data always comes straight from the main register, so it reads BUBBLE whenever the stage is empty.
module pipe_stage_skid #(
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter bit                SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_q;
   logic              in_fire;
   logic              out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign count     = state;

   if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic              rdy_q;

      // rdy_q tracks count!=2 one edge ahead, so in_ready never sees out_ready combinationally.
      assign in_ready = rdy_q & ~reset;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
            rdy_q  <= 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_fire) begin
                     state  <= ONE;
                     main_q <= in_data;
                  end
               end
               ONE: begin
                  if (in_fire && !out_fire) begin
                     state  <= TWO;
                     skid_q <= in_data;
                     rdy_q  <= 1'b0;
                  end else if (!in_fire && out_fire) begin
                     state  <= EMPTY;
                     main_q <= BUBBLE;
                  end else if (in_fire && out_fire) begin
                     main_q <= in_data;
                  end
               end
               TWO: begin
                  if (out_fire) begin
                     state  <= ONE;
                     main_q <= skid_q;
                     skid_q <= BUBBLE;
                     rdy_q  <= 1'b1;
                  end
               end
               default: begin
                  state  <= EMPTY;
                  main_q <= BUBBLE;
                  skid_q <= BUBBLE;
                  rdy_q  <= 1'b1;
               end
            endcase
         end
      end
   end else begin : g_single
      assign in_ready = (~out_valid | out_ready) & ~reset;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
         end else if (in_fire) begin
            state  <= ONE;
            main_q <= in_data;
         end else if (out_fire) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (SKID=1 and SKID=0 side by side)
// Both instances see the same stimulus; each is checked every cycle against a queue-based occupancy model.
module tb_pipe_stage_skid;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [31:0] a_out_data, b_out_data;
   logic [1:0]  a_count, b_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 0;
   bit          saw77    = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] a_seen[$];

   pipe_stage_skid #(.DATA_W(32), .BUBBLE(32'h0), .SKID(1'b1)) u_skid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .count(a_count)
   );

   pipe_stage_skid #(.DATA_W(32), .BUBBLE(32'h0), .SKID(1'b0)) u_single (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a FIFO of capacity 2 (skid) or 1 (single); acceptance follows each variant's ready rule.
   always @(posedge clk) begin : model
      bit ai, ao, bi, bo;
      ai = in_valid && (qa.size() < 2);
      ao = (qa.size() > 0) && out_ready;
      bi = in_valid && ((qb.size() == 0) || out_ready);
      bo = (qb.size() > 0) && out_ready;
      if (reset || flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (ao) void'(qa.pop_front());
         if (ai) qa.push_back(in_data);
         if (bo) void'(qb.pop_front());
         if (bi) qb.push_back(in_data);
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         check("a_in_ready", a_in_ready, (!reset && qa.size() < 2));
         check("a_out_valid", a_out_valid, (qa.size() > 0));
         check("a_out_data", a_out_data, (qa.size() > 0) ? qa[0] : 32'h0);
         check("a_count", a_count, qa.size());
         check("a_count_max", (a_count <= 2), 1);
         check("b_in_ready", b_in_ready, (!reset && (qb.size() == 0 || out_ready)));
         check("b_out_valid", b_out_valid, (qb.size() > 0));
         check("b_out_data", b_out_data, (qb.size() > 0) ? qb[0] : 32'h0);
         check("b_count", b_count, qb.size());
         check("b_count_max", (b_count <= 1), 1);
         if (a_out_valid && out_ready) a_seen.push_back(a_out_data);
         if (a_out_valid && a_out_data == 32'd77) saw77 = 1;
      end
   end

   initial begin
      reset = 1; flush = 0; in_valid = 1; in_data = 32'hDEAD0001; out_ready = 1;

      // reset held for two edges with a valid payload offered
      @(posedge clk); #1; chk_en = 1;
      @(negedge clk);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_count", a_count, 0);
      check("rst_in_ready", a_in_ready, 0);
      check("rst_b_in_ready", b_in_ready, 0);
      tick(); reset = 0; in_valid = 0;
      @(negedge clk);
      check("rel_in_ready", a_in_ready, 1);
      check("rel_b_in_ready", b_in_ready, 1);

      // streaming 1..4 with out_ready=1
      for (int k = 1; k <= 4; k++) begin
         tick(); in_valid = 1; in_data = k;
         @(negedge clk);
         check("stream_in_ready", a_in_ready, 1);
         if (k > 1) begin
            check("stream_a_data", a_out_data, k - 1);
            check("stream_a_count", a_count, 1);
            check("stream_b_data", b_out_data, k - 1);
         end
      end
      tick(); in_valid = 0;
      @(negedge clk);
      check("stream_last", a_out_data, 4);
      check("stream_last_cnt", a_count, 1);
      tick();
      @(negedge clk);
      check("stream_drain_valid", a_out_valid, 0);

      // stall: A1, A2 fill the skid, A3 waits upstream
      a_seen.delete();
      tick(); out_ready = 0; in_valid = 1; in_data = 32'hA1;
      tick(); in_data = 32'hA2;
      tick(); in_data = 32'hA3;
      @(negedge clk);
      check("stall_count", a_count, 2);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_head", a_out_data, 32'hA1);
      tick();
      @(negedge clk);
      check("stall_hold_count", a_count, 2);
      check("stall_hold_head", a_out_data, 32'hA1);
      tick(); out_ready = 1;
      tick();
      @(negedge clk);
      check("unstall_a2", a_out_data, 32'hA2);
      check("unstall_in_ready", a_in_ready, 1);
      tick(); in_valid = 0;
      @(negedge clk);
      check("unstall_a3", a_out_data, 32'hA3);
      tick();
      @(negedge clk);
      check("stall_seen_n", a_seen.size(), 3);
      if (a_seen.size() == 3) begin
         check("stall_seen0", a_seen[0], 32'hA1);
         check("stall_seen1", a_seen[1], 32'hA2);
         check("stall_seen2", a_seen[2], 32'hA3);
      end

      // flush with count=2, then flush again while a payload handshakes
      tick(); out_ready = 0; in_valid = 1; in_data = 32'h10;
      tick(); in_data = 32'h11;
      tick(); in_data = 32'd77; flush = 1;
      @(negedge clk);
      check("pre_flush_count", a_count, 2);
      tick();
      @(negedge clk);
      check("flush_count", a_count, 0);
      check("flush_valid", a_out_valid, 0);
      check("flush_data", a_out_data, 0);
      check("flush_b_count", b_count, 0);
      tick(); flush = 0; in_valid = 0;
      @(negedge clk);
      check("flush2_count", a_count, 0);
      check("flush2_data", a_out_data, 0);
      check("never_77", saw77, 0);

      // SKID=0: count=1 with out_ready=1 still accepts in the same cycle
      tick(); out_ready = 1; in_valid = 1; in_data = 32'h50;
      tick(); in_data = 32'h51;
      @(negedge clk);
      check("single_count", b_count, 1);
      check("single_head", b_out_data, 32'h50);
      check("single_in_ready", b_in_ready, 1);
      tick(); out_ready = 0; in_data = 32'h52;
      @(negedge clk);
      check("single_next", b_out_data, 32'h51);
      check("single_stall_ready", b_in_ready, 0);
      tick(); in_valid = 0; out_ready = 1;
      @(negedge clk);
      check("single_hold", b_out_data, 32'h51);
      tick();
      @(negedge clk);
      check("single_drain", b_count, 0);

      // reset and flush together while full
      tick(); out_ready = 0; in_valid = 1; in_data = 32'h60;
      tick(); in_data = 32'h61;
      tick(); reset = 1; flush = 1; in_data = 32'h62;
      @(negedge clk);
      check("rf_pre_count", a_count, 2);
      check("rf_in_ready", a_in_ready, 0);
      tick(); reset = 0; flush = 0; in_valid = 0;
      @(negedge clk);
      check("rf_count", a_count, 0);
      check("rf_valid", a_out_valid, 0);
      check("rf_data", a_out_data, 0);
      check("rf_in_ready_after", a_in_ready, 1);

      // random traffic against the model
      repeat (600) begin
         tick();
         in_valid  = $urandom_range(0, 1) != 0;
         in_data   = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 31) == 0;
         reset     = $urandom_range(0, 63) == 0;
      end
      tick(); in_valid = 0; flush = 0; reset = 0; out_ready = 1;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
